tx_phy_seq: RTL

TX_PHY_SEQ -- requirements
Module: tx_phy_seq

---
 rtl/tx_phy_seq.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/tx_phy_seq.sv
// TX PHY sequencer: start/end handshake with the PHY, per-byte toggle
// handshake fed from the tx byte FIFO, with immediate-stop and timeout aborts.
module tx_phy_seq #(
  parameter logic [15:0] CONF_TIMEOUT = 16'd5100,
  parameter logic [7:0]  IDLE_DATA    = 8'h55
) (
  input  logic        clk_80m,
  input  logic        bus_clk_resetn,
  input  logic        tx_start_p,
  input  logic [11:0] txv_length,
  input  logic [3:0]  txv_datarate,
  input  logic        txv_immstop,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_dout,
  output logic        fifo_rd_en,
  output logic        phy_txstartend_req,
  input  logic        phy_txstartend_conf,
  output logic        phy_data_req,
  input  logic        phy_data_conf,
  output logic [7:0]  bup_txdata,
  output logic [11:0] txv_length_reg,
  output logic [3:0]  txv_datarate_reg,
  output logic        tx_busy,
  output logic        tx_end_p,
  output logic        tx_abort_p,
  output logic        timeout_err,
  output logic        underrun_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_END   = 3'd5;
  localparam logic [2:0] S_ABORT = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [11:0] len_q, len_d, byte_cnt_q, byte_cnt_d;
  logic [3:0]  rate_q, rate_d;
  logic [15:0] wait_q, wait_d;
  logic [7:0]  data_q, data_d;
  logic        req_q, req_d, dreq_q, dreq_d;
  logic        tmo_q, tmo_d, unr_q, unr_d;
  logic        end_q, end_d, abort_q, abort_d;
  logic        tmo_hit, stop_hit, counting;

  // Timeout fires on the edge the counter would reach CONF_TIMEOUT.
  assign tmo_hit  = (wait_q == CONF_TIMEOUT - 16'd1);
  assign stop_hit = txv_immstop && (state_q != S_IDLE) && (state_q != S_ABORT);
  assign counting = (state_q == S_START) || (state_q == S_FETCH) || (state_q == S_WAIT) ||
                    (state_q == S_END)   || (state_q == S_ABORT);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rate_d     = rate_q;
    byte_cnt_d = byte_cnt_q;
    data_d     = data_q;
    req_d      = req_q;
    dreq_d     = dreq_q;
    tmo_d      = tmo_q;
    unr_d      = unr_q;
    end_d      = 1'b0;
    abort_d    = 1'b0;
    fifo_rd_en = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_start_p && (txv_length != '0)) begin
          state_d    = S_START;
          len_d      = txv_length;
          rate_d     = txv_datarate;
          byte_cnt_d = '0;
          tmo_d      = 1'b0;
          unr_d      = 1'b0;
          req_d      = 1'b1;
        end
      end
      S_START: begin
        if (phy_txstartend_conf) begin
          state_d = S_FETCH;
        end else if (tmo_hit) begin
          tmo_d   = 1'b1;
          state_d = S_ABORT;
        end
      end
      S_FETCH: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = S_LOAD;
        end else if (tmo_hit) begin
          tmo_d   = 1'b1;
          unr_d   = 1'b1;
          state_d = S_ABORT;
        end
      end
      S_LOAD: begin
        data_d     = fifo_dout;
        dreq_d     = ~dreq_q;
        byte_cnt_d = byte_cnt_q + 12'd1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (phy_data_conf == dreq_q) begin
          state_d = (byte_cnt_q == len_q) ? S_END : S_FETCH;
        end else if (tmo_hit) begin
          tmo_d   = 1'b1;
          state_d = S_ABORT;
        end
      end
      S_END: begin
        if (!phy_txstartend_conf) begin
          end_d   = 1'b1;
          state_d = S_IDLE;
        end else if (tmo_hit) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ABORT: begin
        if (!phy_txstartend_conf || tmo_hit) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Immediate stop discards every decision made above, including LOAD side effects.
    if (stop_hit) begin
      state_d    = S_ABORT;
      fifo_rd_en = 1'b0;
      end_d      = 1'b0;
      abort_d    = 1'b0;
      data_d     = data_q;
      dreq_d     = dreq_q;
      byte_cnt_d = byte_cnt_q;
      tmo_d      = tmo_q;
      unr_d      = unr_q;
    end

    if ((state_d == S_END) || (state_d == S_ABORT) || (state_d == S_IDLE)) req_d = 1'b0;

    if (state_d != state_q) wait_d = '0;
    else if (counting)      wait_d = wait_q + 16'd1;
    else                    wait_d = wait_q;
  end

  always_ff @(posedge clk_80m or negedge bus_clk_resetn) begin
    if (!bus_clk_resetn) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      rate_q     <= '0;
      byte_cnt_q <= '0;
      wait_q     <= '0;
      data_q     <= IDLE_DATA;
      req_q      <= 1'b0;
      dreq_q     <= 1'b0;
      tmo_q      <= 1'b0;
      unr_q      <= 1'b0;
      end_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rate_q     <= rate_d;
      byte_cnt_q <= byte_cnt_d;
      wait_q     <= wait_d;
      data_q     <= data_d;
      req_q      <= req_d;
      dreq_q     <= dreq_d;
      tmo_q      <= tmo_d;
      unr_q      <= unr_d;
      end_q      <= end_d;
      abort_q    <= abort_d;
    end
  end

  assign phy_txstartend_req = req_q;
  assign phy_data_req       = dreq_q;
  assign bup_txdata         = ((state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_WAIT))
                              ? data_q : IDLE_DATA;
  assign txv_length_reg     = len_q;
  assign txv_datarate_reg   = rate_q;
  assign tx_busy            = (state_q != S_IDLE);
  assign tx_end_p           = end_q;
  assign tx_abort_p         = abort_q;
  assign timeout_err        = tmo_q;
  assign underrun_err       = unr_q;

endmodule
